fib_stream_checker: RTL and testbench
=====================================

Name: fib_stream_checker

Overview:
Consumer/reader end of the Fibonacci generator datapath. It accepts a WIDTH-bit term stream over a valid/ready handshake and takes the first two accepted terms as seeds. Every later term is checked against the sum of the previous two, modulo 2^WIDTH. It reports progress, the expected next term and the first mismatch; it sits downstream of the generator's output register in bench and self-test configurations.

Parameters:
WIDTH, 4, term width in bits; all sums wrap modulo 2^WIDTH.
CNT_W, 8, width of the term counter and error index.

Ports:
clk  input  1  system clock; rising edge.
reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
start  input  1  one-cycle pulse; clears counters and error state and enters SEED0.
in_valid  input  1  producer has a term on in_data.
in_data  input  WIDTH  Fibonacci term under test.
in_ready  output  1  checker can accept a term; driven combinationally from state only.
exp_data  output  WIDTH  expected next term (prev1+prev0 mod 2^WIDTH); 0 unless in CHECK.
term_cnt  output  CNT_W  number of accepted terms; saturates at all-ones.
err  output  1  sticky mismatch flag.
err_idx  output  CNT_W  term_cnt value of the first mismatching term (0-based index).
busy  output  1  high in SEED0, SEED1 and CHECK.

Behaviour:
- Reset (reset low): state=IDLE; prev0, prev1, term_cnt, err_idx = 0; err=0; in_ready=0; busy=0; exp_data=0.
- Accept: accept = in_valid & in_ready & ~start. Only one term is consumed per accepted cycle. Registered effects appear on the next rising edge (1-cycle latency).
- States:
  - IDLE: in_ready=0. start -> SEED0.
  - SEED0: in_ready=1. On accept: prev0<=in_data, term_cnt=1 -> SEED1.
  - SEED1: in_ready=1. On accept: prev1<=in_data, term_cnt=2 -> CHECK.
  - CHECK: in_ready=1, exp_data=prev0+prev1 (carry discarded).
    - On accept with match: prev0<=prev1, prev1<=in_data, term_cnt++.
    - On accept with mismatch: err<=1, err_idx<=term_cnt (pre-increment value), term_cnt++, then -> ERROR.
  - ERROR: in_ready=0, busy=0. err and err_idx hold. start -> SEED0.
- Seeds are not value-checked; any two values are legal seeds.
- start in any state, including mid-stream: clears term_cnt, err, err_idx, prev0 and prev1, then -> SEED0. A beat offered in that same cycle is not accepted.
- term_cnt saturates at 2^CNT_W-1. Checking continues once saturated; err_idx records the saturated value.
- in_valid low: state holds; the producer may stall indefinitely.
- in_data is ignored whenever accept=0.

Optional Feature:
Macro FIB_CHECK_RESYNC_EN.
- Defined:
  - A mismatch in CHECK does not enter ERROR.
  - err and err_idx are still set on the first mismatch only.
  - The checker resynchronizes: prev0<=prev1, prev1<=in_data, and stays in CHECK.
  - Adds output err_cnt [CNT_W-1:0]: counts mismatches, saturates, and is cleared by reset or start.
- Undefined: the ERROR state halts as above, and the err_cnt port is absent.

Decomposition:
- Shared package fib_pkg:
  - state enum (IDLE, SEED0, SEED1, CHECK, ERROR);
  - default WIDTH/CNT_W constants;
  - saturating-increment function.
- One natural sub-module: fib_sat_counter (CNT_W-bit saturating counter with synchronous clear and enable). It is used for term_cnt and, when enabled, for err_cnt.

Test Plan:
1. reset low mid-cycle with in_valid=1 -> all outputs 0 asynchronously and state IDLE; in_ready=0 until start.
2. start, then stream 0,1,1,2,3,5,8,13,5,2,7,9,0,9,9,2 with in_valid held high -> err=0, term_cnt=16, exp_data=11 afterwards, in_ready high throughout.
3. start, then stream 0,1,1,2,4 -> err=1, err_idx=4, term_cnt=5, in_ready=0; a further in_valid is not accepted. With FIB_CHECK_RESYNC_EN, a following 6 matches (2+4), err_cnt=1 and the checker stays in CHECK.
4. Random in_valid gaps on the sequence from scenario 2 -> results identical to scenario 2; exp_data stable during stalls.
5. start pulsed after 3 accepted terms, coincident with in_valid=1 and in_data=2 -> that beat is dropped, term_cnt=0, state SEED0, and the next term becomes prev0.
6. CNT_W=4 with 20 valid terms -> term_cnt saturates at 15 and err stays 0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci stream checker.
// Optional resync behaviour in the checker is selected by FIB_CHECK_RESYNC_EN.
package fib_pkg;

    localparam int FIB_WIDTH = 4;
    localparam int FIB_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED0 = 3'd1,
        SEED1 = 3'd2,
        CHECK = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module fib_sat_counter
    import fib_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fib_stream_checker.sv
// Checks a valid/ready Fibonacci term stream: two seeds, then each term = sum of previous two.
// Define FIB_CHECK_RESYNC_EN to keep checking after a mismatch and add the err_cnt output.
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] exp_data,
    output logic [CNT_W-1:0] term_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_idx,
    output logic             busy
`ifdef FIB_CHECK_RESYNC_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_prev0;
    logic [WIDTH-1:0] r_prev1;
    logic [WIDTH-1:0] w_sum;
    logic             w_accept;
    logic             w_mismatch;
    logic             r_err;
    logic [CNT_W-1:0] r_err_idx;
    logic [CNT_W-1:0] w_term_cnt;

    assign in_ready   = (r_state == SEED0) || (r_state == SEED1) || (r_state == CHECK);
    assign busy       = in_ready;
    // A start pulse wins over any beat offered in the same cycle.
    assign w_accept   = in_valid & in_ready & ~start;
    assign w_sum      = r_prev0 + r_prev1;
    assign exp_data   = (r_state == CHECK) ? w_sum : '0;
    assign w_mismatch = w_accept && (r_state == CHECK) && (in_data != w_sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = SEED0;
        end else begin
            case (r_state)
                SEED0:   if (w_accept) w_state_next = SEED1;
                SEED1:   if (w_accept) w_state_next = CHECK;
`ifndef FIB_CHECK_RESYNC_EN
                CHECK:   if (w_mismatch) w_state_next = ERROR;
`endif
                default: w_state_next = r_state;
            endcase
        end
    end

    // On a mismatch the history still shifts; with resync this realigns to the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev0 <= '0;
            r_prev1 <= '0;
        end else if (start) begin
            r_prev0 <= '0;
            r_prev1 <= '0;
        end else if (w_accept) begin
            case (r_state)
                SEED0: r_prev0 <= in_data;
                SEED1: r_prev1 <= in_data;
                CHECK: begin
                    r_prev0 <= r_prev1;
                    r_prev1 <= in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else if (start) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else if (w_mismatch && !r_err) begin
            r_err     <= 1'b1;
            r_err_idx <= w_term_cnt;
        end
    end

    fib_sat_counter #(.W(CNT_W)) u_term_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (start),
        .i_en  (w_accept),
        .o_cnt (w_term_cnt)
    );

`ifdef FIB_CHECK_RESYNC_EN
    fib_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (start),
        .i_en  (w_mismatch),
        .o_cnt (err_cnt)
    );
`endif

    assign term_cnt = w_term_cnt;
    assign err      = r_err;
    assign err_idx  = r_err_idx;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Scoreboard bench for fib_stream_checker: driver queues expected values, monitor checks each accepted beat.
module tb_fib_stream_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;

    logic       in_ready, err, busy;
    logic [3:0] exp_data;
    logic [7:0] term_cnt, err_idx;

    logic       in_ready4, err4, busy4;
    logic [3:0] exp_data4, term_cnt4, err_idx4;

`ifdef FIB_CHECK_RESYNC_EN
    logic [7:0] err_cnt;
    logic [3:0] err_cnt4;
`endif

    always #5 clk = ~clk;

    fib_stream_checker #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .exp_data (exp_data),
        .term_cnt (term_cnt),
        .err      (err),
        .err_idx  (err_idx),
        .busy     (busy)
`ifdef FIB_CHECK_RESYNC_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    fib_stream_checker #(.WIDTH(4), .CNT_W(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready4),
        .exp_data (exp_data4),
        .term_cnt (term_cnt4),
        .err      (err4),
        .err_idx  (err_idx4),
        .busy     (busy4)
`ifdef FIB_CHECK_RESYNC_EN
        ,
        .err_cnt  (err_cnt4)
`endif
    );

    typedef struct {
        logic [3:0] exp_d;
        logic [7:0] idx;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Fibonacci mod 16, hand-computed.
    logic [3:0] fib20 [20] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5, 4'd2,
                               4'd7, 4'd9, 4'd0, 4'd9, 4'd9, 4'd2, 4'd11, 4'd13, 4'd8, 4'd5};
    // Expected exp_data at each accept: 0 during seeds, then the term itself.
    logic [3:0] exp20 [20] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5, 4'd2,
                               4'd7, 4'd9, 4'd0, 4'd9, 4'd9, 4'd2, 4'd11, 4'd13, 4'd8, 4'd5};
    int gaps [16] = '{0, 2, 0, 1, 3, 0, 0, 2, 1, 0, 0, 3, 1, 0, 2, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && in_valid && in_ready && !start) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: accepted in_data=%0d at term_cnt=%0d, required no accept",
                         in_data, term_cnt);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                $display("txn idx=%0d data=%0d exp_data=%0d term_cnt=%0d", e.idx, in_data, exp_data, term_cnt);
                check("exp_data_at_accept", 32'(exp_data), 32'(e.exp_d));
                check("term_cnt_at_accept", 32'(term_cnt), 32'(e.idx));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [3:0] e, input logic [7:0] idx, input int gap);
        bit got;
        got = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("stall_exp_data", 32'(exp_data), 32'(e));
            step();
        end
        sb_q.push_back('{e, idx});
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            step();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: idx=%0d not accepted in 20 cycles, required accept", idx);
            void'(sb_q.pop_back());
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_exp_data", 32'(exp_data), 0);
        check("rst_term_cnt", 32'(term_cnt), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        reset = 1'b1;
        step();
        in_valid = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 0);
        check("idle_term_cnt", 32'(term_cnt), 0);
        in_valid = 1'b0;

        // Asynchronous reset mid-stream
        pulse_start();
        send(4'd0, 4'd0, 8'd0, 0);
        send(4'd1, 4'd0, 8'd1, 0);
        send(4'd1, 4'd1, 8'd2, 0);
        in_data = 4'd5;
        #2 reset = 1'b0;
        #1;
        check("async_in_ready", 32'(in_ready), 0);
        check("async_busy", 32'(busy), 0);
        check("async_term_cnt", 32'(term_cnt), 0);
        check("async_exp_data", 32'(exp_data), 0);
        check("async_err", 32'(err), 0);
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 0);

        // Clean stream, back-to-back
        pulse_start();
        check("start_busy", 32'(busy), 1);
        check("start_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 16; i++) send(fib20[i], exp20[i], 8'(i), 0);
        in_valid = 1'b0;
        check("s2_term_cnt", 32'(term_cnt), 16);
        check("s2_err", 32'(err), 0);
        check("s2_exp_data", 32'(exp_data), 11);
        check("s2_in_ready", 32'(in_ready), 1);

        // Mismatch on term 4
        pulse_start();
        send(4'd0, 4'd0, 8'd0, 0);
        send(4'd1, 4'd0, 8'd1, 0);
        send(4'd1, 4'd1, 8'd2, 0);
        send(4'd2, 4'd2, 8'd3, 0);
        send(4'd4, 4'd3, 8'd4, 0);
        in_valid = 1'b0;
        check("s3_err", 32'(err), 1);
        check("s3_err_idx", 32'(err_idx), 4);
        check("s3_term_cnt", 32'(term_cnt), 5);
`ifndef FIB_CHECK_RESYNC_EN
        check("s3_in_ready", 32'(in_ready), 0);
        check("s3_busy", 32'(busy), 0);
        check("s3_exp_data", 32'(exp_data), 0);
        in_valid = 1'b1;
        in_data  = 4'd6;
        repeat (3) step();
        in_valid = 1'b0;
        check("s3_hold_term_cnt", 32'(term_cnt), 5);
        check("s3_hold_err_idx", 32'(err_idx), 4);
`else
        check("s3_in_ready", 32'(in_ready), 1);
        check("s3_exp_data", 32'(exp_data), 6);
        send(4'd6, 4'd6, 8'd5, 0);
        in_valid = 1'b0;
        check("s3_err_cnt", 32'(err_cnt), 1);
        check("s3_resync_term_cnt", 32'(term_cnt), 6);
        check("s3_resync_err_idx", 32'(err_idx), 4);
        check("s3_resync_busy", 32'(busy), 1);
`endif

        // Same stream with stalls
        pulse_start();
        check("s4_err_clear", 32'(err), 0);
        check("s4_err_idx_clear", 32'(err_idx), 0);
        for (int i = 0; i < 16; i++) send(fib20[i], exp20[i], 8'(i), gaps[i]);
        in_valid = 1'b0;
        check("s4_term_cnt", 32'(term_cnt), 16);
        check("s4_err", 32'(err), 0);
        check("s4_exp_data", 32'(exp_data), 11);

        // start coincident with an offered beat
        pulse_start();
        send(4'd0, 4'd0, 8'd0, 0);
        send(4'd1, 4'd0, 8'd1, 0);
        send(4'd1, 4'd1, 8'd2, 0);
        in_data  = 4'd2;
        in_valid = 1'b1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("s5_term_cnt", 32'(term_cnt), 0);
        check("s5_in_ready", 32'(in_ready), 1);
        check("s5_exp_data", 32'(exp_data), 0);
        send(4'd7, 4'd0, 8'd0, 0);
        send(4'd3, 4'd0, 8'd1, 0);
        send(4'd10, 4'd10, 8'd2, 0);
        in_valid = 1'b0;
        check("s5_exp_after", 32'(exp_data), 13);
        check("s5_term_cnt_after", 32'(term_cnt), 3);
        check("s5_err", 32'(err), 0);

        // Saturation on the narrow-counter instance
        pulse_start();
        for (int i = 0; i < 20; i++) send(fib20[i], exp20[i], 8'(i), 0);
        in_valid = 1'b0;
        check("s6_term_cnt4_sat", 32'(term_cnt4), 15);
        check("s6_err4", 32'(err4), 0);
        check("s6_term_cnt", 32'(term_cnt), 20);
        check("s6_err", 32'(err), 0);
        check("s6_exp_data", 32'(exp_data), 13);

        step();
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
